// File: rtl/pcie_msix_pkg.sv
// pcie_msix_pkg: shared FSM encoding and MSI-X table word layout
package pcie_msix_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    localparam logic [1:0] ADDR_LO = 2'd0;
    localparam logic [1:0] ADDR_HI = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CTRL = 2'd3;
    localparam int CTRL_MASK_BIT = 0;
endpackage

// File: rtl/pcie_msix_ctrl_if.sv
// pcie_msix_ctrl_if: cfg_interrupt_msix_* handshake between the controller and the PCIe core
interface pcie_msix_ctrl_if;
    logic        cfg_interrupt_msix_enable;
    logic        cfg_interrupt_msix_mask;
    logic        cfg_interrupt_msix_int;
    logic [63:0] cfg_interrupt_msix_address;
    logic [31:0] cfg_interrupt_msix_data;
    logic        cfg_interrupt_msix_sent;
    logic        cfg_interrupt_msix_fail;
    logic [3:0]  cfg_interrupt_msi_function_number;
    modport master (
        input  cfg_interrupt_msix_enable, cfg_interrupt_msix_mask,
        input  cfg_interrupt_msix_sent, cfg_interrupt_msix_fail,
        output cfg_interrupt_msix_int, cfg_interrupt_msix_address,
        output cfg_interrupt_msix_data, cfg_interrupt_msi_function_number
    );
    modport slave (
        output cfg_interrupt_msix_enable, cfg_interrupt_msix_mask,
        output cfg_interrupt_msix_sent, cfg_interrupt_msix_fail,
        input  cfg_interrupt_msix_int, cfg_interrupt_msix_address,
        input  cfg_interrupt_msix_data, cfg_interrupt_msi_function_number
    );
endinterface

// File: rtl/pcie_msix_rr_arb.sv
// pcie_msix_rr_arb: combinational round-robin select, search starts one past ptr and wraps
module pcie_msix_rr_arb #(
    parameter int N = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          valid
);
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant = IW'((int'(ptr) + i) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcie_msix_ctrl.sv
// pcie_msix_ctrl: MSI-X vector table, pending bits and single-outstanding message issue with retry
module pcie_msix_ctrl
    import pcie_msix_pkg::*;
#(
    parameter int IRQ_COUNT = 8,
    parameter int TBL_ADDR_W = $clog2(IRQ_COUNT) + 2,
    parameter int TIMEOUT = 1024,
    parameter int RETRY_DELAY = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IRQ_COUNT-1:0]  irq_req,
    output logic [IRQ_COUNT-1:0]  pba,
    input  logic                  tbl_wr_en,
    input  logic [TBL_ADDR_W-1:0] tbl_wr_addr,
    input  logic [31:0]           tbl_wr_data,
    input  logic                  tbl_rd_en,
    input  logic [TBL_ADDR_W-1:0] tbl_rd_addr,
    output logic [31:0]           tbl_rd_data,
    output logic                  tbl_rd_valid,
    pcie_msix_ctrl_if.master      msix,
    output logic                  busy
);
    localparam int VW = $clog2(IRQ_COUNT);
    localparam int CW = $clog2(TIMEOUT > RETRY_DELAY ? TIMEOUT : RETRY_DELAY) + 1;

    logic [31:0] addr_lo [IRQ_COUNT];
    logic [31:0] addr_hi [IRQ_COUNT];
    logic [31:0] msg_data [IRQ_COUNT];
    logic [IRQ_COUNT-1:0] mask, pend, eligible, clr, set;
    logic [VW-1:0] ptr, gnt, cur, wr_vec, rd_vec;
    logic [1:0] wr_sel, rd_sel;
    logic [31:0] rd_word;
    logic [CW-1:0] cnt;
    logic gnt_valid, issue, retry;
    state_t state, state_nxt;

    assign wr_vec = tbl_wr_addr[VW+1:2];
    assign wr_sel = tbl_wr_addr[1:0];
    assign rd_vec = tbl_rd_addr[VW+1:2];
    assign rd_sel = tbl_rd_addr[1:0];
    assign eligible = pend & ~mask & {IRQ_COUNT{msix.cfg_interrupt_msix_enable & ~msix.cfg_interrupt_msix_mask}};
    assign clr = issue ? IRQ_COUNT'(1) << gnt : '0;
    assign set = retry ? IRQ_COUNT'(1) << cur : '0;
    assign pba = pend;
    assign busy = state != IDLE;
    assign msix.cfg_interrupt_msi_function_number = 4'd0;

    pcie_msix_rr_arb #(.N(IRQ_COUNT), .IW(VW)) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (gnt),
        .valid (gnt_valid)
    );

    always_comb begin
        rd_word = '0;
        for (int v = 0; v < IRQ_COUNT; v++)
            if (rd_vec == VW'(v))
                rd_word = rd_sel == ADDR_LO ? addr_lo[v] : rd_sel == ADDR_HI ? addr_hi[v] :
                          rd_sel == DATA ? msg_data[v] : 32'(mask[v]) << CTRL_MASK_BIT;
    end

    always_comb begin
        issue = state == IDLE && gnt_valid;
        retry = state == WAIT && (msix.cfg_interrupt_msix_fail || cnt == CW'(TIMEOUT - 1));
        state_nxt = issue ? WAIT :
                    retry ? HOLD :
                    (state == WAIT && msix.cfg_interrupt_msix_sent) ? IDLE :
                    (state == HOLD && cnt == CW'(RETRY_DELAY - 1)) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            ptr <= VW'(IRQ_COUNT - 1);
            cur <= '0;
            pend <= '0;
            msix.cfg_interrupt_msix_int <= 1'b0;
            msix.cfg_interrupt_msix_address <= '0;
            msix.cfg_interrupt_msix_data <= '0;
            tbl_rd_valid <= 1'b0;
            tbl_rd_data <= '0;
            for (int v = 0; v < IRQ_COUNT; v++) begin
                addr_lo[v] <= '0;
                addr_hi[v] <= '0;
                msg_data[v] <= '0;
                mask[v] <= 1'b1;
            end
        end else begin
            state <= state_nxt;
            cnt <= (state != IDLE && state_nxt == state) ? cnt + 1'b1 : '0;
            // a new request or a failed retry re-pends even in the grant cycle
            pend <= (pend & ~clr) | irq_req | set;
            msix.cfg_interrupt_msix_int <= issue;
            if (issue) begin
                ptr <= gnt;
                cur <= gnt;
                msix.cfg_interrupt_msix_address <= {addr_hi[gnt], addr_lo[gnt]};
                msix.cfg_interrupt_msix_data <= msg_data[gnt];
            end
            tbl_rd_valid <= tbl_rd_en;
            if (tbl_rd_en)
                tbl_rd_data <= rd_word;
            for (int v = 0; v < IRQ_COUNT; v++)
                if (tbl_wr_en && wr_vec == VW'(v)) begin
                    if (wr_sel == ADDR_LO) addr_lo[v] <= tbl_wr_data;
                    if (wr_sel == ADDR_HI) addr_hi[v] <= tbl_wr_data;
                    if (wr_sel == DATA) msg_data[v] <= tbl_wr_data;
                    if (wr_sel == CTRL) mask[v] <= tbl_wr_data[CTRL_MASK_BIT];
                end
        end
    end
endmodule

// File: tb/tb_pcie_msix_ctrl.sv
// tb_pcie_msix_ctrl: directed scenarios for the MSI-X controller with hand-computed expectations
module tb_pcie_msix_ctrl;
    import pcie_msix_pkg::*;
    localparam int N = 8;
    localparam int TO = 1024;
    localparam int RD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] irq_req, pba;
    logic tbl_wr_en, tbl_rd_en, tbl_rd_valid, busy;
    logic [4:0] tbl_wr_addr, tbl_rd_addr;
    logic [31:0] tbl_wr_data, tbl_rd_data;
    int tests = 0;
    int fails = 0;
    int int_cnt = 0;

    pcie_msix_ctrl_if msix ();

    pcie_msix_ctrl #(.IRQ_COUNT(N), .TIMEOUT(TO), .RETRY_DELAY(RD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_req),
        .pba          (pba),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_data  (tbl_wr_data),
        .tbl_rd_en    (tbl_rd_en),
        .tbl_rd_addr  (tbl_rd_addr),
        .tbl_rd_data  (tbl_rd_data),
        .tbl_rd_valid (tbl_rd_valid),
        .msix         (msix.master),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (msix.cfg_interrupt_msix_int === 1'b1) int_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_req = '0;
        tbl_wr_en = 1'b0;
        tbl_rd_en = 1'b0;
        tbl_wr_addr = '0;
        tbl_rd_addr = '0;
        tbl_wr_data = '0;
        msix.cfg_interrupt_msix_enable = 1'b1;
        msix.cfg_interrupt_msix_mask = 1'b0;
        msix.cfg_interrupt_msix_sent = 1'b0;
        msix.cfg_interrupt_msix_fail = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input int v, input int w, input logic [31:0] d);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = 5'(v * 4 + w);
        tbl_wr_data = d;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic rd(input int v, input int w, output logic [31:0] d, output logic ok);
        tbl_rd_en = 1'b1;
        tbl_rd_addr = 5'(v * 4 + w);
        tick();
        d = tbl_rd_data;
        ok = tbl_rd_valid;
        tbl_rd_en = 1'b0;
    endtask

    task automatic prog(input int v, input logic [63:0] a, input logic [31:0] d);
        wr(v, int'(ADDR_LO), a[31:0]);
        wr(v, int'(ADDR_HI), a[63:32]);
        wr(v, int'(DATA), d);
        wr(v, int'(CTRL), 32'h0);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_req = m;
        tick();
        irq_req = '0;
    endtask

    task automatic wait_int(input int lim, output int n);
        n = 0;
        while (msix.cfg_interrupt_msix_int !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic complete();
        msix.cfg_interrupt_msix_sent = 1'b1;
        tick();
        msix.cfg_interrupt_msix_sent = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic ok;
        int c0;
        do_reset();
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b0) begin fails++; $display("FAIL reset_int got %b want 0", msix.cfg_interrupt_msix_int); end
        tests++; if (msix.cfg_interrupt_msix_address !== 64'h0) begin fails++; $display("FAIL reset_addr got %h want 0", msix.cfg_interrupt_msix_address); end
        tests++; if (msix.cfg_interrupt_msix_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", msix.cfg_interrupt_msix_data); end
        tests++; if ({pba, busy, tbl_rd_valid} !== '0) begin fails++; $display("FAIL reset_misc pba=%h busy=%b rdv=%b want 0", pba, busy, tbl_rd_valid); end
        tests++; if (tbl_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", tbl_rd_data); end
        tests++; if (msix.cfg_interrupt_msi_function_number !== 4'd0) begin fails++; $display("FAIL func_num got %h want 0", msix.cfg_interrupt_msi_function_number); end
        for (int v = 0; v < N; v++)
            for (int w = 0; w < 4; w++) begin
                rd(v, w, d, ok);
                tests++;
                if (d !== (w == 3 ? 32'h1 : 32'h0) || ok !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_tbl v%0d w%0d got %h/%b want %h/1", v, w, d, ok, (w == 3 ? 32'h1 : 32'h0));
                end
            end
        c0 = int_cnt;
        pulse(8'h04);
        repeat (5) tick();
        tests++; if (int_cnt !== c0) begin fails++; $display("FAIL masked_no_int got %0d pulses want 0", int_cnt - c0); end
        tests++; if (pba !== 8'h04) begin fails++; $display("FAIL masked_pba got %h want 04", pba); end
    endtask

    task automatic test_table();
        logic [31:0] d;
        logic ok;
        do_reset();
        wr(0, 2, 32'hAAAA_0000);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = 5'd2;
        tbl_wr_data = 32'hBBBB_0000;
        tbl_rd_en = 1'b1;
        tbl_rd_addr = 5'd2;
        tick();
        tbl_wr_en = 1'b0;
        tbl_rd_en = 1'b0;
        tests++; if (tbl_rd_data !== 32'hAAAA_0000 || tbl_rd_valid !== 1'b1) begin fails++; $display("FAIL rdw_old got %h/%b want aaaa0000/1", tbl_rd_data, tbl_rd_valid); end
        tick();
        tests++; if (tbl_rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse got %b want 0", tbl_rd_valid); end
        rd(0, 2, d, ok);
        tests++; if (d !== 32'hBBBB_0000) begin fails++; $display("FAIL rdw_new got %h want bbbb0000", d); end
        wr(7, 3, 32'hFFFF_FFFE);
        rd(7, 3, d, ok);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL ctrl_bits got %h want 0", d); end
        wr(7, 3, 32'hFFFF_FFFF);
        rd(7, 3, d, ok);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL ctrl_mask got %h want 1", d); end
    endtask

    task automatic test_single();
        do_reset();
        prog(3, 64'h0000_0001_FEE0_0000, 32'h43);
        pulse(8'h08);
        tests++; if (pba !== 8'h08 || msix.cfg_interrupt_msix_int !== 1'b0) begin fails++; $display("FAIL single_t1 pba=%h int=%b want 08/0", pba, msix.cfg_interrupt_msix_int); end
        tick();
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b1) begin fails++; $display("FAIL single_int got %b want 1", msix.cfg_interrupt_msix_int); end
        tests++; if (msix.cfg_interrupt_msix_address !== 64'h0000_0001_FEE0_0000) begin fails++; $display("FAIL single_addr got %h want 00000001fee00000", msix.cfg_interrupt_msix_address); end
        tests++; if (msix.cfg_interrupt_msix_data !== 32'h43) begin fails++; $display("FAIL single_data got %h want 43", msix.cfg_interrupt_msix_data); end
        tests++; if (pba !== 8'h00 || busy !== 1'b1) begin fails++; $display("FAIL single_t2 pba=%h busy=%b want 00/1", pba, busy); end
        tick();
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b0) begin fails++; $display("FAIL single_pulse got %b want 0", msix.cfg_interrupt_msix_int); end
        tick();
        tick();
        complete();
        tests++; if (pba !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL single_done pba=%h busy=%b want 00/0", pba, busy); end
        tests++; if (msix.cfg_interrupt_msix_data !== 32'h43) begin fails++; $display("FAIL single_hold got %h want 43", msix.cfg_interrupt_msix_data); end
    endtask

    task automatic test_round_robin();
        int n, c0;
        do_reset();
        for (int v = 0; v < N; v++) prog(v, 64'hFEE0_0000 + 64'(v * 16), 32'h100 + 32'(v));
        c0 = int_cnt;
        pulse(8'hFF);
        for (int v = 0; v < N; v++) begin
            wait_int(6, n);
            tests++;
            if (msix.cfg_interrupt_msix_int !== 1'b1 || msix.cfg_interrupt_msix_data !== 32'h100 + 32'(v)) begin
                fails++;
                $display("FAIL rr_grant%0d int=%b data=%h want 1/%h", v, msix.cfg_interrupt_msix_int, msix.cfg_interrupt_msix_data, 32'h100 + 32'(v));
            end
            tick();
            tick();
            complete();
        end
        repeat (5) tick();
        tests++; if (int_cnt - c0 !== 8) begin fails++; $display("FAIL rr_count got %0d want 8", int_cnt - c0); end
        tests++; if (pba !== 8'h00) begin fails++; $display("FAIL rr_pba got %h want 00", pba); end
    endtask

    task automatic test_fail_retry();
        int n;
        do_reset();
        prog(5, 64'hFEE0_5000, 32'h55);
        pulse(8'h20);
        wait_int(4, n);
        msix.cfg_interrupt_msix_fail = 1'b1;
        tick();
        msix.cfg_interrupt_msix_fail = 1'b0;
        tests++; if (pba !== 8'h20) begin fails++; $display("FAIL fail_pba got %h want 20", pba); end
        wait_int(40, n);
        tests++; if (n !== RD + 1) begin fails++; $display("FAIL fail_holdoff got %0d cycles want %0d", n, RD + 1); end
        tests++; if (msix.cfg_interrupt_msix_address !== 64'hFEE0_5000 || msix.cfg_interrupt_msix_data !== 32'h55) begin fails++; $display("FAIL fail_reissue got %h/%h want fee05000/55", msix.cfg_interrupt_msix_address, msix.cfg_interrupt_msix_data); end
        complete();
        tests++; if (pba !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL fail_done pba=%h busy=%b want 00/0", pba, busy); end
    endtask

    task automatic test_timeout_gate();
        int n, c0;
        do_reset();
        prog(6, 64'hFEE0_6000, 32'h66);
        pulse(8'h40);
        wait_int(4, n);
        repeat (TO - 1) tick();
        tests++; if (pba !== 8'h00 || busy !== 1'b1) begin fails++; $display("FAIL to_early pba=%h busy=%b want 00/1", pba, busy); end
        tick();
        tests++; if (pba !== 8'h40) begin fails++; $display("FAIL to_pba got %h want 40", pba); end
        wait_int(40, n);
        tests++; if (n !== RD + 1 || msix.cfg_interrupt_msix_data !== 32'h66) begin fails++; $display("FAIL to_retry got %0d/%h want %0d/66", n, msix.cfg_interrupt_msix_data, RD + 1); end
        complete();
        msix.cfg_interrupt_msix_enable = 1'b0;
        c0 = int_cnt;
        pulse(8'h40);
        repeat (4) tick();
        tests++; if (int_cnt !== c0 || pba !== 8'h40) begin fails++; $display("FAIL en_gate pulses=%0d pba=%h want 0/40", int_cnt - c0, pba); end
        msix.cfg_interrupt_msix_enable = 1'b1;
        wait_int(2, n);
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b1) begin fails++; $display("FAIL en_release got %b want 1", msix.cfg_interrupt_msix_int); end
        complete();
        msix.cfg_interrupt_msix_mask = 1'b1;
        c0 = int_cnt;
        pulse(8'h40);
        repeat (4) tick();
        tests++; if (int_cnt !== c0 || pba !== 8'h40) begin fails++; $display("FAIL fm_gate pulses=%0d pba=%h want 0/40", int_cnt - c0, pba); end
        msix.cfg_interrupt_msix_mask = 1'b0;
        wait_int(2, n);
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b1) begin fails++; $display("FAIL fm_release got %b want 1", msix.cfg_interrupt_msix_int); end
        complete();
    endtask

    task automatic test_wait_update_reset();
        int n, c0;
        do_reset();
        prog(1, 64'hFEE0_1000, 32'h11);
        pulse(8'h02);
        wait_int(4, n);
        irq_req = 8'h02;
        tbl_wr_en = 1'b1;
        tbl_wr_addr = 5'd6;
        tbl_wr_data = 32'h22;
        tick();
        irq_req = '0;
        tbl_wr_en = 1'b0;
        tests++; if (msix.cfg_interrupt_msix_data !== 32'h11 || msix.cfg_interrupt_msix_address !== 64'hFEE0_1000) begin fails++; $display("FAIL wait_snapshot got %h/%h want fee01000/11", msix.cfg_interrupt_msix_address, msix.cfg_interrupt_msix_data); end
        tests++; if (pba !== 8'h02) begin fails++; $display("FAIL wait_pend got %h want 02", pba); end
        tick();
        complete();
        wait_int(3, n);
        tests++; if (msix.cfg_interrupt_msix_int !== 1'b1 || msix.cfg_interrupt_msix_data !== 32'h22) begin fails++; $display("FAIL second_issue int=%b data=%h want 1/22", msix.cfg_interrupt_msix_int, msix.cfg_interrupt_msix_data); end
        tick();
        rst_n = 1'b0;
        tick();
        tests++; if ({msix.cfg_interrupt_msix_int, msix.cfg_interrupt_msix_address, msix.cfg_interrupt_msix_data} !== '0) begin fails++; $display("FAIL rst_wait_out got %b/%h/%h want 0", msix.cfg_interrupt_msix_int, msix.cfg_interrupt_msix_address, msix.cfg_interrupt_msix_data); end
        tests++; if ({pba, busy, tbl_rd_valid} !== '0) begin fails++; $display("FAIL rst_wait_misc pba=%h busy=%b rdv=%b want 0", pba, busy, tbl_rd_valid); end
        rst_n = 1'b1;
        c0 = int_cnt;
        complete();
        repeat (3) tick();
        tests++; if (busy !== 1'b0 || int_cnt !== c0) begin fails++; $display("FAIL rst_late_sent busy=%b pulses=%0d want 0/0", busy, int_cnt - c0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_table();
        test_single();
        test_round_robin();
        test_fail_retry();
        test_timeout_gate();
        test_wait_update_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
